spis_reg_bridge: RTL and testbench

Register-file command bridge that sits directly downstream of the SPI slave receive path and upstream of its transmit path. It consumes received bytes (`RxData`/`RxValid`), decodes a byte-level read/write command protocol, and updates an 8-entry × 8-bit register file. It supplies the next byte to be shifted out on `TxData`. All logic runs in the `Sclk` domain, so state advances only while the master clocks transfers.

---
 rtl/spis_reg_bridge.sv | 148 ++++++++++++++
 tb/tb_spis_reg_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spis_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spis_reg_bridge
// Purpose  : Byte-level command decoder between an SPI slave receive path and
//            its transmit path. Decodes read/write burst commands and drives an
//            8 x 8-bit register file; reg 7 is a read-only device ID.
// Ports    : Sclk      - clock, all state changes on posedge
//            rst       - asynchronous active-high reset
//            RxData    - received byte, qualified by RxValid
//            RxValid   - one-cycle strobe per received byte
//            TxData    - byte the slave loads for the next transfer
//            reg_out   - flattened register file, reg i at [8*i+7:8*i]
//            wr_strobe - one-cycle pulse per register write
//            wr_addr   - address of the write, valid with wr_strobe
//            busy      - burst in progress
//            err       - sticky protocol error
// Config   : SPIS_REG_AUTOINC_EN defined -> address increments per data byte;
//            undefined -> address holds for the whole burst.
// Revision : 1.0 - initial release
// ============================================================================
module spis_reg_bridge #(
    parameter logic [7:0] DEVICE_ID = 8'hA5,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        Sclk,
    input  logic        rst,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic [7:0]  TxData,
    output logic [63:0] reg_out,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  addr;
    logic [3:0]  remain;
    logic [7:0]  regs [0:6];

    // Read view of the whole file: entries 0..6 are storage, 7 is the ID.
    logic [7:0]  rd_mux [0:7];
    logic [2:0]  addr_nxt;
    logic [3:0]  remain_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_rdmux
            assign rd_mux[gi] = regs[gi];
        end
        for (gi = 0; gi < 8; gi++) begin : g_regout
            assign reg_out[8*gi +: 8] = rd_mux[gi];
        end
    endgenerate
    assign rd_mux[7] = DEVICE_ID;

`ifdef SPIS_REG_AUTOINC_EN
    assign addr_nxt = addr + 3'd1;
`else
    assign addr_nxt = addr;
`endif

    assign remain_nxt = remain - 4'd1;

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= 3'd0;
            remain    <= 4'd0;
            TxData    <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= 3'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (RxValid) begin
                case (state)
                    ST_IDLE: begin
                        if (RxData[3]) begin
                            // Reserved bit set: flag and ignore the command.
                            err    <= 1'b1;
                            TxData <= 8'h00;
                        end else begin
                            addr   <= RxData[2:0];
                            remain <= {1'b0, RxData[6:4]} + 4'd1;
                            busy   <= 1'b1;
                            if (RxData[7]) begin
                                state  <= ST_READ;
                                TxData <= rd_mux[RxData[2:0]];
                            end else begin
                                state  <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (addr != 3'd7) begin
                            for (int i = 0; i < 7; i++) begin
                                if (addr == 3'(i)) begin
                                    regs[i] <= RxData;
                                end
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                        end else begin
                            // Read-only ID register: data dropped, burst continues.
                            err <= 1'b1;
                        end
                        addr   <= addr_nxt;
                        remain <= remain_nxt;
                        if (remain_nxt == 4'd0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    ST_READ: begin
                        // Incoming byte is a dummy; it only paces the burst.
                        addr   <= addr_nxt;
                        remain <= remain_nxt;
                        if (remain_nxt == 4'd0) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            TxData <= 8'h00;
                        end else begin
                            TxData <= rd_mux[addr_nxt];
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spis_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spis_reg_bridge
// Purpose  : Self-checking bench for spis_reg_bridge. Directed table vectors,
//            hand-written burst sequences and random byte streams, all checked
//            against a queue-based transaction model of the command protocol.
//            Honours SPIS_REG_AUTOINC_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spis_reg_bridge;

`ifdef SPIS_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam logic [7:0] ID = 8'hA5;

    logic        Sclk;
    logic        rst;
    logic [7:0]  RxData;
    logic        RxValid;
    logic [7:0]  TxData;
    logic [63:0] reg_out;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic        busy;
    logic        err;

    spis_reg_bridge #(.DEVICE_ID(8'hA5), .RESET_VAL(8'h00)) dut (
        .Sclk      (Sclk),
        .rst       (rst),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .TxData    (TxData),
        .reg_out   (reg_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .err       (err)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    int checks = 0;
    int errors = 0;

    // ---------------- transaction model ----------------
    logic [7:0] m_regs [0:6];
    int         m_q[$];          // addresses still to be accessed in this burst
    bit         m_is_read;
    logic [7:0] m_tx;
    bit         m_err;
    bit         m_strobe;
    logic [2:0] m_waddr;

    function automatic logic [7:0] m_rd(input int a);
        return (a == 7) ? ID : m_regs[a];
    endfunction

    function automatic logic [63:0] m_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = m_rd(i);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_regs[i] = 8'h00;
        m_q.delete();
        m_is_read = 1'b0;
        m_tx      = 8'h00;
        m_err     = 1'b0;
        m_strobe  = 1'b0;
        m_waddr   = 3'd0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        int a;
        m_strobe = 1'b0;
        if (!v) return;
        if (m_q.size() == 0) begin
            if (b[3]) begin
                m_err = 1'b1;
            end else begin
                for (int k = 0; k <= int'(b[6:4]); k++)
                    m_q.push_back((int'(b[2:0]) + (AUTOINC ? k : 0)) % 8);
                m_is_read = b[7];
                if (m_is_read) m_tx = m_rd(int'(b[2:0]));
            end
        end else begin
            a = m_q.pop_front();
            if (m_is_read) begin
                m_tx = (m_q.size() == 0) ? 8'h00 : m_rd(m_q[0]);
            end else if (a == 7) begin
                m_err = 1'b1;
            end else begin
                m_regs[a] = b;
                m_strobe  = 1'b1;
                m_waddr   = 3'(a);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".TxData"},    64'(TxData),    64'(m_tx));
        chk({tag, ".busy"},      64'(busy),      64'(m_q.size() != 0));
        chk({tag, ".wr_strobe"}, 64'(wr_strobe), 64'(m_strobe));
        chk({tag, ".err"},       64'(err),       64'(m_err));
        chk({tag, ".reg_out"},   reg_out,        m_flat());
        if (m_strobe) chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_waddr));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        @(negedge Sclk);
        RxValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge Sclk);
            #1;
            model_step(1'b0, 8'h00);
            check_all("idle");
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge Sclk);
        RxData  = b;
        RxValid = 1'b1;
        @(posedge Sclk);
        #1;
        model_step(1'b1, b);
        check_all("byte");
        if (gap > 0) idle(gap);
    endtask

    task automatic do_reset();
        @(negedge Sclk);
        RxValid = 1'b0;
        rst     = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        chk("reset.wr_addr", 64'(wr_addr), 64'd0);
        @(negedge Sclk);
        rst = 1'b0;
        @(posedge Sclk);
        #1;
        check_all("post_reset");
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        bit         busy;
        bit         strobe;
        logic [2:0] waddr;
        bit         err;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [7:0] b;
        rst     = 1'b1;
        RxValid = 1'b0;
        RxData  = 8'h00;
        model_reset();

        vt[0] = '{8'h87, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0};  // read len1 @7
        vt[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};  // dummy ends read
        vt[2] = '{8'h08, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};  // reserved bit
        vt[3] = '{8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};  // write len1 @1
        vt[4] = '{8'h5A, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};  // data -> reg1
        vt[5] = '{8'h81, 8'h5A, 1'b1, 1'b0, 3'd0, 1'b1};  // read len1 @1
        vt[6] = '{8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};
        vt[7] = '{8'h90, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};  // read len2 @0
        vt[8] = '{8'hC3, AUTOINC ? 8'h5A : 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
        vt[9] = '{8'h3C, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(vt[i].rx, 0);
            chk($sformatf("vec%0d.TxData", i), 64'(TxData), 64'(vt[i].tx));
            chk($sformatf("vec%0d.busy", i),   64'(busy),   64'(vt[i].busy));
            chk($sformatf("vec%0d.strobe", i), 64'(wr_strobe), 64'(vt[i].strobe));
            if (vt[i].strobe)
                chk($sformatf("vec%0d.wr_addr", i), 64'(wr_addr), 64'(vt[i].waddr));
            chk($sformatf("vec%0d.err", i),    64'(err),    64'(vt[i].err));
        end
        idle(2);

        // -------- write burst len3 @2 --------
        do_reset();
        send(8'h22, 1);
        send(8'h11, 0);
        chk("wb3.addr0", 64'(wr_addr), 64'd2);
        send(8'h22, 0);
        chk("wb3.addr1", 64'(wr_addr), AUTOINC ? 64'd3 : 64'd2);
        send(8'h33, 0);
        chk("wb3.addr2", 64'(wr_addr), AUTOINC ? 64'd4 : 64'd2);
        chk("wb3.strobe", 64'(wr_strobe), 64'd1);
        idle(1);
        chk("wb3.regs", 64'(reg_out[39:16]), AUTOINC ? 64'h332211 : 64'h000033);
        chk("wb3.err", 64'(err), 64'd0);
        chk("wb3.busy", 64'(busy), 64'd0);

        // -------- write len2 @6 running into read-only reg 7 --------
        send(8'h16, 0);
        send(8'hAA, 0);
        send(8'hBB, 1);
        chk("w67.reg6", 64'(reg_out[55:48]), AUTOINC ? 64'hAA : 64'hBB);
        chk("w67.reg7", 64'(reg_out[63:56]), 64'hA5);
        chk("w67.err", 64'(err), AUTOINC ? 64'd1 : 64'd0);
        send(8'h01, 0);
        send(8'h77, 2);
        chk("w67.err_sticky", 64'(err), AUTOINC ? 64'd1 : 64'd0);

        // -------- asynchronous reset in the middle of a burst --------
        do_reset();
        send(8'h30, 0);
        send(8'h44, 0);
        @(negedge Sclk);
        RxValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.regs", reg_out, {8'hA5, 56'h0});
        chk("arst.busy", 64'(busy), 64'd0);
        check_all("arst");
        @(negedge Sclk);
        rst = 1'b0;
        send(8'h80, 0);
        chk("arst.read_busy", 64'(busy), 64'd1);
        chk("arst.read_tx", 64'(TxData), 64'h00);
        send(8'h00, 1);

        // -------- fixed-address burst (repeated access to one register) ----
        do_reset();
        send(8'h21, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        chk("fix.waddr", 64'(wr_addr), AUTOINC ? 64'd3 : 64'd1);
        idle(1);
        chk("fix.regs", 64'(reg_out[31:8]), AUTOINC ? 64'h030201 : 64'h000003);

        // -------- full 8-byte burst from address 0 --------
        do_reset();
        send(8'h70, 0);
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 0);
        idle(1);

        // -------- random stream against the model --------
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                b = 8'($urandom);
                if (m_q.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b0;
                send(b, $urandom_range(0, 2));
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
